// File: rtl/chacha_rounds_if.sv
// Request/result bundle for the chacha_rounds permutation engine.
// The hchacha request bit exists only when CHACHA_ROUNDS_HCHACHA_EN is defined.
interface chacha_rounds_if;
  logic         start;
`ifdef CHACHA_ROUNDS_HCHACHA_EN
  logic         hchacha;
`endif
  logic [511:0] data_in;
  logic         ready;
  logic [511:0] data_out;
  logic         data_out_valid;

`ifdef CHACHA_ROUNDS_HCHACHA_EN
  modport master (output start, hchacha, data_in, input ready, data_out, data_out_valid);
  modport slave  (input start, hchacha, data_in, output ready, data_out, data_out_valid);
`else
  modport master (output start, data_in, input ready, data_out, data_out_valid);
  modport slave  (input start, data_in, output ready, data_out, data_out_valid);
`endif
endinterface

// File: rtl/chacha_rounds.sv
// Iterative ChaCha permutation (ROUNDS rounds, NUM_QR quarterrounds per cycle) with feed-forward.
// Optional macro CHACHA_ROUNDS_HCHACHA_EN adds the hchacha input that bypasses the feed-forward.
module chacha_rounds #(
  parameter int ROUNDS = 20,
  parameter int NUM_QR = 4
) (
  input logic            clk,
  input logic            reset_n,
  chacha_rounds_if.slave bus
);
  localparam int GROUPS  = 8 / NUM_QR;
  localparam int DOUBLES = ROUNDS / 2;
  localparam int QW      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int DW      = $clog2(DOUBLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  generate
    if (ROUNDS < 2 || ROUNDS > 20 || (ROUNDS % 2) != 0) begin : g_bad_rounds
      $error("chacha_rounds: ROUNDS must be even and within 2..20");
    end
    if (NUM_QR != 1 && NUM_QR != 2 && NUM_QR != 4) begin : g_bad_num_qr
      $error("chacha_rounds: NUM_QR must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] quarter(input logic [31:0] a_in, input logic [31:0] b_in,
                                           input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  logic [1:0]    state_reg, state_next;
  logic [QW-1:0] qr_ctr_reg, qr_ctr_next;
  logic [DW-1:0] dr_ctr_reg, dr_ctr_next;
  logic [31:0]   work_reg [16];
  logic [31:0]   work_next [16];
  logic [31:0]   init_reg [16];
  logic [31:0]   init_next [16];
  logic [511:0]  out_reg, out_next;
  logic          accept, finalise, skip_ff;

  assign accept   = (state_reg != ROUND) && bus.start;
  // Finalisation takes its own cycle after the last QR group, so the adder reads registers only.
  assign finalise = (state_reg == ROUND) && (dr_ctr_reg == DW'(DOUBLES));

`ifdef CHACHA_ROUNDS_HCHACHA_EN
  logic skip_ff_reg;
  always_ff @(posedge clk) begin
    if (!reset_n)    skip_ff_reg <= 1'b0;
    else if (accept) skip_ff_reg <= bus.hchacha;
  end
  assign skip_ff = skip_ff_reg;
`else
  assign skip_ff = 1'b0;
`endif

  // Per-lane word selection: column QR q uses (q,4+q,8+q,12+q); diagonals rotate rows 1..3.
  logic [3:0]  ia [NUM_QR];
  logic [3:0]  ib [NUM_QR];
  logic [3:0]  ic [NUM_QR];
  logic [3:0]  id [NUM_QR];
  logic [31:0] ra [NUM_QR];
  logic [31:0] rb [NUM_QR];
  logic [31:0] rc [NUM_QR];
  logic [31:0] rd [NUM_QR];

  generate
    for (genvar gi = 0; gi < NUM_QR; gi++) begin : g_lane
      logic [2:0] qidx;
      assign qidx   = 3'(int'(qr_ctr_reg) * NUM_QR + gi);
      assign ia[gi] = {2'b00, qidx[1:0]};
      assign ib[gi] = {2'b01, qidx[1:0] + {1'b0, qidx[2]}};
      assign ic[gi] = {2'b10, qidx[1:0] + {qidx[2], 1'b0}};
      assign id[gi] = {2'b11, qidx[1:0] + {qidx[2], qidx[2]}};
      assign {ra[gi], rb[gi], rc[gi], rd[gi]} =
        quarter(work_reg[ia[gi]], work_reg[ib[gi]], work_reg[ic[gi]], work_reg[id[gi]]);
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    qr_ctr_next = qr_ctr_reg;
    dr_ctr_next = dr_ctr_reg;
    out_next    = out_reg;
    for (int w = 0; w < 16; w++) begin
      work_next[w] = work_reg[w];
      init_next[w] = init_reg[w];
    end

    if (accept) begin
      for (int w = 0; w < 16; w++) begin
        work_next[w] = bus.data_in[511-32*w -: 32];
        init_next[w] = bus.data_in[511-32*w -: 32];
      end
      qr_ctr_next = '0;
      dr_ctr_next = '0;
      state_next  = ROUND;
    end else if (finalise) begin
      for (int w = 0; w < 16; w++) begin
        out_next[511-32*w -: 32] = skip_ff ? work_reg[w] : work_reg[w] + init_reg[w];
      end
      state_next = DONE;
    end else if (state_reg == ROUND) begin
      for (int l = 0; l < NUM_QR; l++) begin
        work_next[ia[l]] = ra[l];
        work_next[ib[l]] = rb[l];
        work_next[ic[l]] = rc[l];
        work_next[id[l]] = rd[l];
      end
      if (qr_ctr_reg == QW'(GROUPS - 1)) begin
        qr_ctr_next = '0;
        dr_ctr_next = dr_ctr_reg + DW'(1);
      end else begin
        qr_ctr_next = qr_ctr_reg + QW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      qr_ctr_reg <= '0;
      dr_ctr_reg <= '0;
      out_reg    <= '0;
      for (int w = 0; w < 16; w++) begin
        work_reg[w] <= '0;
        init_reg[w] <= '0;
      end
    end else begin
      state_reg  <= state_next;
      qr_ctr_reg <= qr_ctr_next;
      dr_ctr_reg <= dr_ctr_next;
      out_reg    <= out_next;
      for (int w = 0; w < 16; w++) begin
        work_reg[w] <= work_next[w];
        init_reg[w] <= init_next[w];
      end
    end
  end

  assign bus.ready          = (state_reg != ROUND);
  assign bus.data_out_valid = (state_reg == DONE);
  assign bus.data_out       = out_reg;
endmodule
